// File: rtl/fsm_trace_buffer.sv
// fsm_trace_buffer: logs {A,B} state transitions (prev state, new state, Q, dwell) into a FIFO.
// Latency: an event sampled at edge k is at the head (OUT_VALID=1) right after edge k when the FIFO was empty.
// Backpressure: OUT_VALID/OUT_READY; head held while stalled; an event that finds the FIFO full with no pop is dropped and sets sticky OVF.
module fsm_trace_buffer #(
  parameter int DEPTH = 4,
  parameter int TW    = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   A,
  input  logic                   B,
  input  logic                   Q,
  input  logic                   OUT_READY,
  output logic                   OUT_VALID,
  output logic [TW+4:0]          OUT_DATA,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   FULL,
  output logic                   OVF
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = TW + 5;

  // Tracker state
  logic [1:0]    prev_q,  prev_d;
  logic [TW-1:0] dwell_q, dwell_d;
  logic          ovf_q,   ovf_d;

  // FIFO bookkeeping and storage (storage is never reset; it is only
  // presented while the FIFO holds entries)
  logic [AW-1:0] head_q,  head_d;
  logic [AW-1:0] tail_q,  tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] mem_q [DEPTH];

  logic [1:0]    state_cur;
  logic          event_w;
  logic          full_w;
  logic          empty_w;
  logic          pop_w;
  logic          push_w;
  logic [EW-1:0] entry_w;

  assign state_cur = {A, B};
  assign full_w    = (count_q == CW'(DEPTH));
  assign empty_w   = (count_q == '0);

  // An event is any change of the observed state against the last recorded one
  assign event_w = (state_cur != prev_q);
  assign entry_w = {prev_q, A, B, Q, dwell_q};

  // A pop frees a slot in the same edge, so a full FIFO can still accept
  assign pop_w  = !empty_w && OUT_READY;
  assign push_w = event_w && (!full_w || pop_w);

  // Next-state for tracker, pointers, occupancy and overflow flag
  always_comb begin
    prev_d  = prev_q;
    dwell_d = dwell_q;
    ovf_d   = ovf_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (event_w) begin
      prev_d  = state_cur;
      dwell_d = '0;
    end else if (dwell_q != {TW{1'b1}}) begin
      dwell_d = dwell_q + TW'(1);
    end

    if (pop_w) begin
      head_d = head_q + AW'(1);
    end
    if (push_w) begin
      tail_d = tail_q + AW'(1);
    end

    if (push_w && !pop_w) begin
      count_d = count_q + CW'(1);
    end else if (pop_w && !push_w) begin
      count_d = count_q - CW'(1);
    end

    // Dropped entry: tracker still moves on, only the record is lost
    if (event_w && full_w && !pop_w) begin
      ovf_d = 1'b1;
    end
  end

  // Control registers with asynchronous reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_q  <= 2'b00;
      dwell_q <= '0;
      ovf_q   <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      prev_q  <= prev_d;
      dwell_q <= dwell_d;
      ovf_q   <= ovf_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage write at the tail
  always_ff @(posedge CLK) begin
    if (push_w) begin
      mem_q[tail_q] <= entry_w;
    end
  end

  // Outputs are decoded from registers only; head data is forced to zero when empty
  assign OUT_VALID = !empty_w;
  assign OUT_DATA  = empty_w ? '0 : mem_q[head_q];
  assign COUNT     = count_q;
  assign FULL      = full_w;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_fsm_trace_buffer.sv
// tb_fsm_trace_buffer: directed test-plan sequences plus random traffic against a queue model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: OUT_READY driven per step from directed tables or $urandom.
module tb_fsm_trace_buffer;

  localparam int DEPTH = 4;
  localparam int TW    = 4;
  localparam int EW    = TW + 5;
  localparam int DMAX  = (1 << TW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          A = 1'b0;
  logic          B = 1'b0;
  logic          Q = 1'b0;
  logic          OUT_READY = 1'b0;
  logic          OUT_VALID;
  logic [EW-1:0] OUT_DATA;
  logic [2:0]    COUNT;
  logic          FULL;
  logic          OVF;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of entries plus the tracker's view of the FSM
  logic [EW-1:0] mq[$];
  logic [1:0]    m_prev = 2'b00;
  int            m_dwell = 0;
  logic          m_ovf = 1'b0;

  fsm_trace_buffer #(.DEPTH(DEPTH), .TW(TW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .Q         (Q),
    .OUT_READY (OUT_READY),
    .OUT_VALID (OUT_VALID),
    .OUT_DATA  (OUT_DATA),
    .COUNT     (COUNT),
    .FULL      (FULL),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_prev  = 2'b00;
    m_dwell = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    logic [EW-1:0] exp_data;
    exp_data = (mq.size() != 0) ? mq[0] : '0;
    check({tag, ".valid"}, 32'(OUT_VALID), 32'(mq.size() != 0));
    check({tag, ".count"}, 32'(COUNT),     32'(mq.size()));
    check({tag, ".full"},  32'(FULL),      32'(mq.size() == DEPTH));
    check({tag, ".ovf"},   32'(OVF),       32'(m_ovf));
    check({tag, ".data"},  32'(OUT_DATA),  32'(exp_data));
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it
  task automatic step(input logic a, input logic b, input logic q, input logic rdy, input string tag);
    logic          pop;
    logic          ev;
    logic [EW-1:0] ent;
    A = a; B = b; Q = q; OUT_READY = rdy;
    @(posedge CLK);
    pop = (mq.size() != 0) && rdy;
    ev  = ({a, b} != m_prev);
    ent = {m_prev, a, b, q, TW'(m_dwell)};
    if (pop) void'(mq.pop_front());
    if (ev) begin
      if (mq.size() < DEPTH) mq.push_back(ent);
      else m_ovf = 1'b1;
      m_prev  = {a, b};
      m_dwell = 0;
    end else if (m_dwell < DMAX) begin
      m_dwell++;
    end
    #1;
    compare_model(tag);
  endtask

  // Reset pulse between edges; outputs must clear before any clock edge
  task automatic reset_pulse(input string tag);
    RST = 1'b1;
    #1;
    check({tag, ".rst_valid"}, 32'(OUT_VALID), 32'd0);
    check({tag, ".rst_count"}, 32'(COUNT),     32'd0);
    check({tag, ".rst_full"},  32'(FULL),      32'd0);
    check({tag, ".rst_ovf"},   32'(OVF),       32'd0);
    check({tag, ".rst_data"},  32'(OUT_DATA),  32'd0);
    model_reset();
    #1;
    RST = 1'b0;
  endtask

  initial begin
    logic [EW-1:0] held;
    logic [1:0]    st;

    // Power-on reset held across two edges
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    compare_model("por");
    RST = 1'b0;

    // Single transition after three edges in 00
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, "single_hold");
    step(1'b1, 1'b0, 1'b1, 1'b0, "single_evt");
    check("single_data", 32'(OUT_DATA), 32'h053);
    check("single_cnt",  32'(COUNT),    32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1, "single_pop");
    check("single_empty", 32'(OUT_VALID), 32'd0);

    // Dwell saturation: 20 edges in 00, then move to 01
    step(1'b0, 1'b0, 1'b0, 1'b0, "sat_enter");
    repeat (20) step(1'b0, 1'b0, 1'b0, 1'b1, "sat_hold");
    step(1'b0, 1'b1, 1'b0, 1'b0, "sat_evt");
    check("sat_dwell", 32'(OUT_DATA[TW-1:0]),   32'hF);
    check("sat_prev",  32'(OUT_DATA[EW-1:EW-2]), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, "sat_pop");

    // Fill and overflow, starting from state 00 with an empty FIFO
    step(1'b0, 1'b0, 1'b0, 1'b1, "fill_pre");
    step(1'b0, 1'b0, 1'b0, 1'b1, "fill_pre_pop");
    step(1'b1, 1'b0, 1'b0, 1'b0, "fill1");
    step(1'b1, 1'b1, 1'b1, 1'b0, "fill2");
    step(1'b0, 1'b1, 1'b0, 1'b0, "fill3");
    step(1'b0, 1'b0, 1'b1, 1'b0, "fill4");
    check("fill_cnt",  32'(COUNT), 32'd4);
    check("fill_full", 32'(FULL),  32'd1);
    check("fill_ovf",  32'(OVF),   32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, "ovf_evt");
    check("ovf_cnt", 32'(COUNT), 32'd4);
    check("ovf_set", 32'(OVF),   32'd1);
    check("ovf_head", 32'(OUT_DATA[EW-1:EW-4]), 32'b0010);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1, "ovf_drain");
    check("ovf_sticky", 32'(OVF),   32'd1);
    check("ovf_empty",  32'(COUNT), 32'd0);

    // Reset mid-operation clears OVF and leaves prev = 00
    step(1'b1, 1'b0, 1'b0, 1'b0, "pre_rst");
    reset_pulse("midrst");

    // Full with simultaneous push and pop
    step(1'b1, 1'b0, 1'b0, 1'b0, "pp_fill1");
    step(1'b1, 1'b1, 1'b0, 1'b0, "pp_fill2");
    step(1'b0, 1'b1, 1'b1, 1'b0, "pp_fill3");
    step(1'b0, 1'b0, 1'b0, 1'b0, "pp_fill4");
    check("pp_full", 32'(FULL), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b1, "pp_both");
    check("pp_cnt", 32'(COUNT), 32'd4);
    check("pp_ovf", 32'(OVF),   32'd0);
    check("pp_head", 32'(OUT_DATA[EW-1:EW-4]), 32'b1011);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, "pp_drain");
    check("pp_last", 32'(OUT_DATA[EW-1:TW]), 32'b00101);
    step(1'b1, 1'b0, 1'b0, 1'b1, "pp_drain_last");

    // Backpressure stability with two entries held
    step(1'b1, 1'b1, 1'b0, 1'b0, "bp_push1");
    step(1'b0, 1'b1, 1'b1, 1'b0, "bp_push2");
    held = OUT_DATA;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, "bp_stall");
      check("bp_stable", 32'(OUT_DATA), 32'(held));
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, "bp_pop1");
    check("bp_cnt1", 32'(COUNT), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, "bp_pop2");
    check("bp_cnt0", 32'(COUNT), 32'd0);

    // Random traffic with varying consumer pressure and occasional reset
    st = 2'b01;
    for (int i = 0; i < 600; i++) begin
      int rdy_pct;
      rdy_pct = ((i / 60) % 3 == 0) ? 20 : (((i / 60) % 3 == 1) ? 90 : 50);
      if ($urandom_range(0, 3) == 0) st = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) reset_pulse("rnd_rst");
      step(st[1], st[0], 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < rdy_pct), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_trace_buffer.md
# fsm_trace_buffer

Downstream observer for the enable-driven state machine (`top`: inputs CLK, E; outputs A, B, Q). It watches the machine's state bits {A,B} and output Q every clock. On each state change it records a transition entry into a small FIFO: previous state, new state, Q, and cycles spent in the previous state. A consumer drains the FIFO over a valid/ready handshake. The block provides debug and trace visibility of the FSM without touching its logic.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- TW, 4: width of the dwell-time field, in bits.

- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- A  in  1  FSM state bit A.
- B  in  1  FSM state bit B.
- Q  in  1  FSM output Q.
- OUT_READY  in  1  consumer accepts the head entry.
- OUT_VALID  out  1  head entry available; equals !EMPTY.
- OUT_DATA  out  TW+5  head entry {PA, PB, A, B, Q, DWELL}; MSB is PA.
- COUNT  out  $clog2(DEPTH)+1  number of entries held.
- FULL  out  1  COUNT == DEPTH.
- OVF  out  1  sticky; set when an entry is dropped.

## Operation
- Internal registers:
  - PREV[1:0]: last recorded state {A,B}.
  - DWELL_CNT[TW-1:0]: cycles since the last event.
  - FIFO storage, head/tail pointers, count.
- Event detection, at each rising edge: EVENT = ({A,B} != PREV), sampled at that edge.
- On EVENT:
  - Form the entry {PREV, A, B, Q, DWELL_CNT}.
  - Set PREV <= {A,B}.
  - Clear DWELL_CNT to 0.
- Without EVENT: DWELL_CNT increments and saturates at 2^TW−1. It never wraps.
- Pop = OUT_VALID && OUT_READY at the edge. Pop removes the head and advances the head pointer modulo DEPTH.
- Push = EVENT && (!FULL || Pop). The entry is written at the tail, and the tail advances modulo DEPTH.
- Simultaneous push and pop:
  - Both occur and COUNT is unchanged.
  - This is legal even when FULL.
  - When EMPTY, there is no pop (OUT_VALID=0), so the push proceeds and COUNT becomes 1.
- Overflow: EVENT && FULL && !Pop.
  - The entry is dropped and OVF is set to 1.
  - PREV and DWELL_CNT still update as for a normal event.
  - OVF clears only on RST.
- Handshake rules:
  - OUT_DATA is held stable while OUT_VALID && !OUT_READY.
  - The consumer may hold OUT_READY high continuously.
  - OUT_READY while EMPTY is ignored.
- Entries leave the FIFO in strict arrival order.
- Reset (async, immediate on RST rising, not waiting for CLK):
  - PREV = 2'b00, DWELL_CNT = 0.
  - Pointers = 0, COUNT = 0.
  - OUT_VALID = 0, FULL = 0, OVF = 0.
  - OUT_DATA = 0.
  - FIFO contents are don't-care but are not presented, because OUT_VALID = 0.
- Reset mid-operation: all entries are discarded. The first edge after RST deasserts treats 2'b00 as the previous state.

## Timing
- Capture latency is one edge.
  - An event sampled at edge k with the FIFO empty gives OUT_VALID=1 and OUT_DATA equal to that entry after edge k.
  - It is visible for the whole of cycle k+1.
- COUNT, FULL, OVF and OUT_VALID are registered and change only on edges or reset.
- OUT_DATA is a mux of registered storage by the head pointer, with no combinational path from A/B/Q.
- Throughput: one push and one pop per cycle, sustained.
- A, B and Q must meet setup to CLK, as when driven by the synchronous `top`.

## Test plan
- Reset:
  - Stimulus: RST=1 for 2 edges, then pulse RST between edges after traffic.
  - Required response: OUT_VALID=0, COUNT=0, FULL=0, OVF=0 immediately, without waiting for an edge.
- Single transition:
  - Stimulus: after reset, hold {A,B}=00 for 3 edges, then present {A,B}=10 with Q=1 at edge 4.
  - Required response: OUT_VALID=1, COUNT=1, OUT_DATA={0,0,1,0,1,4'd3}.
  - Then OUT_READY=1 for one edge gives OUT_VALID=0, COUNT=0.
- Dwell saturation:
  - Stimulus: hold {A,B}=00 for 20 edges, then change to 01 with Q=0.
  - Required response: OUT_DATA DWELL=4'hF and PREV field 00.
- Fill and overflow:
  - Stimulus: OUT_READY=0; toggle the state 00→10→11→01→00 (4 events).
  - Required response: COUNT=4, FULL=1, OVF=0.
  - Stimulus: a 5th change (→10).
  - Required response: COUNT=4, OVF=1.
  - Stimulus: drain with OUT_READY=1.
  - Required response: the 4 original entries come out in order, and OVF stays 1.
- Full with simultaneous push and pop:
  - Stimulus: FULL, OUT_READY=1, and a state change on the same edge.
  - Required response: COUNT stays 4, OVF stays 0, the oldest entry is removed, and the new entry is last in drain order.
- Backpressure stability:
  - Stimulus: 2 entries held, OUT_READY=0 for 5 edges.
  - Required response: OUT_DATA is unchanged throughout.
  - Stimulus: then OUT_READY=1.
  - Required response: entries are popped on consecutive edges.
